add_serial_ctrl: RTL and testbench



---
 rtl/add_serial_ctrl.sv | 146 ++++++++++++++
 tb/tb_add_serial_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial_ctrl.sv
// Bit-serial add/subtract sequencer. One 1-bit full adder is reused for every
// bit position: operands are shifted out LSB-first, sum bits are shifted in at
// the MSB, and the carry lives in a flop between bits. Requests and results
// travel over two independent valid/ready handshakes.

// Single-bit full adder, the only arithmetic element in the sequencer.
module add_1b (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic o,
  output logic co
);
  assign o  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module add_serial_ctrl #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             live_q;              // low until the first edge after reset release
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic             prev_carry_q, prev_carry_d;  // carry into the MSB
  logic [CW-1:0]    count_q, count_d;

  logic             add_o;
  logic             add_co;
  logic             last_bit;

  // The adder always looks at the current LSBs and the held carry.
  add_1b u_add (a_sh_q[0], b_sh_q[0], carry_q, add_o, add_co);

  assign last_bit  = (count_q == CW'(WIDTH - 1));
  assign in_ready  = live_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  // Results come straight from the datapath state; nothing touches it between
  // the output handshake and the next accepted request, so values persist.
  assign sum  = s_sh_q;
  assign cout = carry_q;
  assign ovf  = carry_q ^ prev_carry_q;

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every target gets a hold-value default up front so no path through
    // the case can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    s_sh_d       = s_sh_q;
    carry_d      = carry_q;
    prev_carry_d = prev_carry_q;
    count_d      = count_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          // Subtraction is A + ~B + 1: invert B here, force the carry-in to 1.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          count_d = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {add_o, s_sh_q[WIDTH-1:1]};
        carry_d = add_co;
        if (count_q == CW'(WIDTH - 2)) begin
          prev_carry_d = add_co;
        end
        if (last_bit) begin
          state_d = ST_DONE;
        end else begin
          // Holding the count on the last bit keeps it from wrapping.
          count_d = count_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears the whole datapath so an aborted operation
  // leaves no residual carry or partial sum behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      live_q       <= 1'b0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      s_sh_q       <= '0;
      carry_q      <= 1'b0;
      prev_carry_q <= 1'b0;
      count_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values of the others, which the shift chains depend on.
      state_q      <= state_d;
      live_q       <= 1'b1;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      s_sh_q       <= s_sh_d;
      carry_q      <= carry_d;
      prev_carry_q <= prev_carry_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Self-checking bench for add_serial_ctrl: an 8-bit instance for directed and
// random traffic, a 2-bit instance for exhaustive coverage. Expected results
// are pushed to a scoreboard queue at request time and popped at completion.
module tb_add_serial_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       in_valid8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, cout8, ovf8;
  logic [7:0] sum8;

  // 2-bit instance
  logic       in_valid2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0, out_ready2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       in_ready2, out_valid2, cout2, ovf2;
  logic [1:0] sum2;

  add_serial_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  add_serial_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   passed  = 0;
  int   total   = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference model: full-width integer add, overflow from operand/result signs.
  function automatic res_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic su, input int w);
    logic [63:0] mask, bb, full;
    res_t        r;
    mask   = (64'd1 << w) - 64'd1;
    bb     = su ? (~{32'd0, bv} & mask) : ({32'd0, bv} & mask);
    full   = ({32'd0, av} & mask) + bb + (su ? 64'd1 : {63'd0, ci});
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (av[w-1] == bb[w-1]) && (r.sum[w-1] != av[w-1]);
    return r;
  endfunction

  function automatic logic rdy(input int w);
    return (w == 2) ? in_ready2 : in_ready8;
  endfunction

  function automatic logic vld(input int w);
    return (w == 2) ? out_valid2 : out_valid8;
  endfunction

  function automatic res_t obs(input int w);
    res_t r;
    r.sum  = (w == 2) ? {30'd0, sum2} : {24'd0, sum8};
    r.cout = (w == 2) ? cout2 : cout8;
    r.ovf  = (w == 2) ? ovf2 : ovf8;
    return r;
  endfunction

  // Issue one request (called at a negedge); returns at the negedge after the accept edge.
  task automatic send(input int w, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic su);
    int n = 0;
    exp_q.push_back(model({24'd0, av}, {24'd0, bv}, ci, su, w));
    while (!rdy(w) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(w)) begin
      total++;
      $display("FAIL accept_timeout w=%0d: in_ready=0 after %0d cycles, required 1", w, n);
      return;
    end
    if (w == 2) begin
      a2 = av[1:0]; b2 = bv[1:0]; cin2 = ci; sub2 = su; in_valid2 = 1'b1;
    end else begin
      a8 = av; b8 = bv; cin8 = ci; sub8 = su; in_valid8 = 1'b1;
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    in_valid8 = 1'b0;
    acc_cyc   = cyc;
  endtask

  // Wait for out_valid, stall the consumer, then take the result.
  task automatic collect(input int w, input int stall, output res_t got,
                         output int lat, output bit ok);
    int n = 0;
    ok  = 1'b1;
    lat = 0;
    got = '0;
    while (!vld(w) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!vld(w)) begin
      total++;
      $display("FAIL done_timeout w=%0d: out_valid=0 after %0d cycles, required 1", w, n);
      ok = 1'b0;
      return;
    end
    lat = cyc - acc_cyc;
    repeat (stall) @(negedge clk);
    got = obs(w);
    if (w == 2) out_ready2 = 1'b1;
    else        out_ready8 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready8, out_valid8, sum8, cout8, ovf8, in_ready2, out_valid2, sum2, cout2, ovf2} !== '0)
      $display("FAIL reset_values: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, required all 0",
               in_ready8, out_valid8, sum8, cout8, ovf8);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready8 !== 1'b0) $display("FAIL ready_before_edge: got %b, required 0", in_ready8);
    else passed++;
    @(negedge clk);
    total++;
    if ({in_ready8, in_ready2} !== 2'b11)
      $display("FAIL ready_after_release: got %b%b, required 11", in_ready8, in_ready2);
    else passed++;
  endtask

  task automatic test_basic();
    res_t got, exp;
    int   lat;
    bit   ok, run_ok;
    send(8, 8'h05, 8'h03, 1'b0, 1'b0);
    run_ok = 1'b1;
    // Eight RUN cycles follow the accept edge; the block must look busy in all of them.
    for (int i = 0; i < 8; i++) begin
      if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0) run_ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!run_ok) $display("FAIL run_busy: in_ready/out_valid seen high during RUN, required 0");
    else passed++;
    collect(8, 0, got, lat, ok);
    exp = exp_q.pop_front();
    if (ok) begin
      // out_valid rises with the 8th edge after the accept edge: 9 cycles counting the accept cycle.
      total++;
      if (lat !== 8) $display("FAIL basic_latency: got %0d edges after accept, required 8", lat);
      else passed++;
      total++;
      if (got !== exp || exp !== {32'h08, 1'b0, 1'b0})
        $display("FAIL basic_add: got sum=%h cout=%b ovf=%b, required sum=08 cout=0 ovf=0",
                 got.sum, got.cout, got.ovf);
      else passed++;
    end
  endtask

  task automatic test_carry();
    logic [7:0] ta [2] = '{8'hFF, 8'h7F};
    logic [7:0] tb [2] = '{8'h00, 8'h01};
    logic       tc [2] = '{1'b1, 1'b0};
    res_t got, exp;
    int   lat;
    bit   ok;
    for (int i = 0; i < 2; i++) begin
      send(8, ta[i], tb[i], tc[i], 1'b0);
      collect(8, 0, got, lat, ok);
      exp = exp_q.pop_front();
      if (ok) begin
        total++;
        if (got !== exp)
          $display("FAIL carry_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   i, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
        else passed++;
      end
    end
  endtask

  task automatic test_sub();
    logic [7:0] ta [3] = '{8'h03, 8'h80, 8'h10};
    logic [7:0] tb [3] = '{8'h05, 8'h01, 8'h10};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    res_t got, exp;
    int   lat;
    bit   ok;
    for (int i = 0; i < 3; i++) begin
      send(8, ta[i], tb[i], tc[i], 1'b1);
      collect(8, 0, got, lat, ok);
      exp = exp_q.pop_front();
      if (ok) begin
        total++;
        if (got !== exp)
          $display("FAIL sub_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   i, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    res_t exp;
    int   n = 0;
    send(8, 8'h3C, 8'h0F, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    // Scramble every input while the operation runs.
    while (!out_valid8 && n < 64) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      sub8 = 1'($urandom); in_valid8 = 1'($urandom);
      @(negedge clk);
      n++;
    end
    total++;
    if (!out_valid8) begin
      $display("FAIL bp_done_timeout: out_valid=0 after %0d cycles, required 1", n);
      in_valid8 = 1'b0;
      return;
    end
    passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid8 !== 1'b1 || obs(8) !== exp)
        $display("FAIL bp_hold_%0d: got vld=%b sum=%h cout=%b ovf=%b, required vld=1 sum=%h cout=%b ovf=%b",
                 i, out_valid8, sum8, cout8, ovf8, exp.sum, exp.cout, exp.ovf);
      else passed++;
      a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'($urandom);
      @(negedge clk);
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    total++;
    if ({out_valid8, in_ready8} !== 2'b01)
      $display("FAIL bp_release: got vld=%b rdy=%b, required vld=0 rdy=1", out_valid8, in_ready8);
    else passed++;
    total++;
    if (obs(8) !== exp)
      $display("FAIL bp_retain: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               sum8, cout8, ovf8, exp.sum, exp.cout, exp.ovf);
    else passed++;
  endtask

  task automatic test_reset_mid();
    res_t got, exp;
    int   lat;
    bit   ok;
    send(8, 8'h55, 8'hAA, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if ({in_ready8, out_valid8, sum8, cout8, ovf8} !== '0)
      $display("FAIL mid_reset_clear: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, required all 0",
               in_ready8, out_valid8, sum8, cout8, ovf8);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid8 !== 1'b0) $display("FAIL mid_reset_no_valid: got %b, required 0", out_valid8);
    else passed++;
    send(8, 8'h01, 8'h01, 1'b0, 1'b0);
    collect(8, 0, got, lat, ok);
    exp = exp_q.pop_front();
    if (ok) begin
      total++;
      if (got !== exp)
        $display("FAIL after_reset_add: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
      else passed++;
    end
  endtask

  task automatic test_random();
    res_t got, exp;
    int   lat;
    bit   ok;
    for (int i = 0; i < 200; i++) begin
      send(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      collect(8, $urandom_range(0, 3), got, lat, ok);
      exp = exp_q.pop_front();
      if (ok) begin
        total++;
        if (got !== exp)
          $display("FAIL random_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   i, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
        else passed++;
      end
    end
  endtask

  task automatic test_exhaustive_w2();
    res_t       got, exp;
    int         lat;
    bit         ok;
    logic [7:0] av, bv;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int si = 0; si < 2; si++) begin
          av = 8'(ai);
          bv = 8'(bi);
          send(2, av, bv, av[0] ^ bv[1], 1'(si));
          collect(2, 0, got, lat, ok);
          exp = exp_q.pop_front();
          if (ok) begin
            total++;
            if (got !== exp)
              $display("FAIL w2_a%0d_b%0d_s%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                       ai, bi, si, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
            else passed++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_exhaustive_w2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
